// File: rtl/tinker_pkg.sv
// Shared types and constants for the Tinker instruction fetch stage.
package tinker_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 64;
    localparam logic [ADDR_W-1:0] RESET_PC = 64'h0000_0000_0000_2000;

    typedef enum logic [0:0] {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [INST_W-1:0] word;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

    // Instruction words are 4-byte aligned; the low address bits are ignored.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~64'h0000_0000_0000_0003;
    endfunction

endpackage

// File: rtl/tinker_fetch_checker.sv
// Simulation-only protocol checks for the fetch stage's response accounting.
module tinker_fetch_checker #(
    parameter int CW = 3
) (
    input logic          clk,
    input logic          reset,
    input logic          imem_rsp_valid,
    input logic [CW-1:0] outstanding,
    input logic [CW-1:0] discard_cnt
);

    rsp_has_request: assert property (@(posedge clk) disable iff (reset)
        !(imem_rsp_valid && (outstanding == {CW{1'b0}})))
        else $error("tinker_fetch: response with no request outstanding");

    discard_bounded: assert property (@(posedge clk) disable iff (reset)
        discard_cnt <= outstanding)
        else $error("tinker_fetch: discard count exceeds outstanding requests");

endmodule

// File: rtl/tinker_inst_fifo.sv
// Synchronous FIFO of fetched {instruction word, pc}; flush overrides push and pop.
module tinker_inst_fifo
    import tinker_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [CW-1:0] count,
    output fetch_entry_t head
);

    localparam logic [PW:0] PTR_ZERO = {(PW + 1){1'b0}};
    localparam logic [PW:0] PTR_ONE  = {{PW{1'b0}}, 1'b1};
    localparam logic [PW:0] PTR_FULL = (PW + 1)'(DEPTH);

    fetch_entry_t mem_r [DEPTH];
    logic [PW:0]  wptr_r;
    logic [PW:0]  rptr_r;
    logic [PW:0]  fill_s;
    logic         do_push_s;
    logic         do_pop_s;

    assign fill_s    = wptr_r - rptr_r;
    assign count     = CW'(fill_s);
    assign head      = mem_r[rptr_r[PW-1:0]];
    assign do_push_s = push && (fill_s != PTR_FULL);
    assign do_pop_s  = pop && (fill_s != PTR_ZERO);

    // Pointer and storage update; storage is cleared only by reset so the head reads zero after it.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_r <= PTR_ZERO;
            rptr_r <= PTR_ZERO;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {$bits(fetch_entry_t){1'b0}};
            end
        end else if (flush) begin
            wptr_r <= PTR_ZERO;
            rptr_r <= PTR_ZERO;
        end else begin
            if (do_push_s) begin
                mem_r[wptr_r[PW-1:0]] <= push_data;
                wptr_r                <= wptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/tinker_fetch.sv
// Tinker instruction fetch: PC, in-order memory request/response tracking,
// redirect with discard of stale responses, halt, and the instruction buffer.
module tinker_fetch #(
    parameter int FIFO_DEPTH = 4,
    parameter logic [tinker_pkg::ADDR_W-1:0] RESET_PC = tinker_pkg::RESET_PC
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic                          imem_req_valid,
    input  logic                          imem_req_ready,
    output logic [tinker_pkg::ADDR_W-1:0] imem_req_addr,
    input  logic                          imem_rsp_valid,
    input  logic [tinker_pkg::INST_W-1:0] imem_rsp_data,
    input  logic                          redirect_valid,
    input  logic [tinker_pkg::ADDR_W-1:0] redirect_pc,
    input  logic                          halt,
    output logic                          inst_valid,
    input  logic                          inst_ready,
    output logic [tinker_pkg::INST_W-1:0] instruction,
    output logic [tinker_pkg::ADDR_W-1:0] inst_pc
);

    import tinker_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW - 1){1'b0}}, 1'b1};
    localparam logic [CW:0]   CREDIT   = (CW + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP = 64'h0000_0000_0000_0004;

    fetch_state_t      state_r;
    fetch_state_t      state_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_s;
    logic [ADDR_W-1:0] rsp_pc_r;
    logic [ADDR_W-1:0] rsp_pc_s;
    logic [CW-1:0]     outstanding_r;
    logic [CW-1:0]     outstanding_s;
    logic [CW-1:0]     discard_r;
    logic [CW-1:0]     discard_s;
    logic [CW-1:0]     fifo_count_s;
    fetch_entry_t      head_s;
    fetch_entry_t      entry_s;
    logic              req_valid_s;
    logic              req_fire_s;
    logic              rsp_ok_s;
    logic              push_s;
    logic              pop_s;

    // Credit counts both buffered words and words still in flight, so every response has a slot.
    assign req_valid_s = !reset && (state_r == FETCH) && !halt &&
                         (({1'b0, outstanding_r} + {1'b0, fifo_count_s}) < CREDIT);
    assign req_fire_s  = req_valid_s && imem_req_ready;
    assign rsp_ok_s    = imem_rsp_valid && (outstanding_r != CNT_ZERO);
    assign push_s      = rsp_ok_s && !redirect_valid && (discard_r == CNT_ZERO);
    assign pop_s       = inst_valid && inst_ready;
    assign entry_s     = '{word: imem_rsp_data, pc: rsp_pc_r};

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = pc_r;
    assign inst_valid     = (fifo_count_s != CNT_ZERO);
    assign instruction    = head_s.word;
    assign inst_pc        = head_s.pc;

    tinker_inst_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (entry_s),
        .pop       (pop_s),
        .flush     (redirect_valid),
        .count     (fifo_count_s),
        .head      (head_s)
    );

    // Next-state for PC, response tracking and the FETCH/HALTED machine.
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        rsp_pc_s      = rsp_pc_r;
        discard_s     = discard_r;
        outstanding_s = outstanding_r + {{(CW - 1){1'b0}}, req_fire_s}
                                      - {{(CW - 1){1'b0}}, rsp_ok_s};
        if (redirect_valid) begin
            // Everything still owed by memory after this cycle belongs to the old path.
            pc_s      = word_align(redirect_pc);
            rsp_pc_s  = word_align(redirect_pc);
            discard_s = outstanding_s;
            state_s   = FETCH;
        end else begin
            if (req_fire_s) begin
                pc_s = pc_r + PC_STEP;
            end else begin
                pc_s = pc_r;
            end
            if (rsp_ok_s && (discard_r != CNT_ZERO)) begin
                discard_s = discard_r - CNT_ONE;
            end else if (push_s) begin
                rsp_pc_s = rsp_pc_r + PC_STEP;
            end else begin
                discard_s = discard_r;
            end
            case (state_r)
                FETCH:   state_s = halt ? HALTED : FETCH;
                HALTED:  state_s = HALTED;
                default: state_s = FETCH;
            endcase
        end
    end

    // Control register update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= FETCH;
            pc_r          <= RESET_PC;
            rsp_pc_r      <= RESET_PC;
            outstanding_r <= CNT_ZERO;
            discard_r     <= CNT_ZERO;
        end else begin
            state_r       <= state_s;
            pc_r          <= pc_s;
            rsp_pc_r      <= rsp_pc_s;
            outstanding_r <= outstanding_s;
            discard_r     <= discard_s;
        end
    end

    tinker_fetch_checker #(
        .CW (CW)
    ) u_checker (
        .clk            (clk),
        .reset          (reset),
        .imem_rsp_valid (imem_rsp_valid),
        .outstanding    (outstanding_r),
        .discard_cnt    (discard_r)
    );

endmodule

// File: tb/tb_tinker_fetch.sv
// Directed and randomized bench for tinker_fetch with an in-order memory model
// and a reference model of the expected request and instruction streams.
module tb_tinker_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        halt = 1'b0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] instruction;
    logic [63:0] inst_pc;

    tinker_fetch #(
        .FIFO_DEPTH (4),
        .RESET_PC   (64'h0000_0000_0000_2000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .instruction    (instruction),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } pend_t;

    pend_t       mq[$];
    int          cyc = 0;
    int          last_due = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          ntot = 0;
    int          npass = 0;
    int          nfail = 0;
    int          n_fire = 0;
    int          n_pop = 0;
    int          f0;
    int          p0;
    logic [63:0] exp_pc = 64'h2000;
    logic [63:0] exp_req = 64'h2000;
    logic [63:0] last_fire = 64'h0;
    logic [63:0] last_pop_pc = 64'h0;
    logic        s_rv;
    logic        s_iv;
    logic [63:0] s_ra;
    logic [63:0] s_ipc;
    logic [31:0] s_ins;

    // Memory contents: a distinct word per address, including across 64-bit wrap.
    function automatic logic [31:0] memword(input logic [63:0] a);
        return a[33:2] ^ {a[63:34], 2'b10} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        ntot++;
        assert (obs === expv) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // One clock: inputs are already set; sample, score, advance the memory model.
    task automatic cycle();
        bit fire;
        bit pop;
        int due;
        #1;
        s_rv  = imem_req_valid;
        s_ra  = imem_req_addr;
        s_iv  = inst_valid;
        s_ipc = inst_pc;
        s_ins = instruction;
        fire  = (s_rv === 1'b1) && imem_req_ready;
        pop   = (s_iv === 1'b1) && inst_ready;
        if (pop) begin
            chk("inst_pc", s_ipc, exp_pc);
            chk("instruction", {32'h0, s_ins}, {32'h0, memword(exp_pc)});
            exp_pc      = exp_pc + 64'd4;
            last_pop_pc = s_ipc;
            n_pop++;
        end
        if (imem_rsp_valid && mq.size() > 0) void'(mq.pop_front());
        if (fire) begin
            chk("req_addr", s_ra, exp_req);
            exp_req   = exp_req + 64'd4;
            last_fire = s_ra;
            n_fire++;
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{s_ra, due});
        end
        if (redirect_valid) begin
            exp_pc  = redirect_pc & ~64'd3;
            exp_req = redirect_pc & ~64'd3;
        end
        @(posedge clk);
        cyc++;
        if (reset) begin
            mq.delete();
            exp_pc   = 64'h2000;
            exp_req  = 64'h2000;
            last_due = cyc;
        end
        @(negedge clk);
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memword(mq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        halt           = 1'b0;
        cycle();
        cycle();
        chk("rst_req_valid", {63'h0, s_rv}, 64'h0);
        chk("rst_req_addr", s_ra, 64'h2000);
        chk("rst_inst_valid", {63'h0, s_iv}, 64'h0);
        chk("rst_instruction", {32'h0, s_ins}, 64'h0);
        chk("rst_inst_pc", s_ipc, 64'h0);
        reset = 1'b0;
    endtask

    initial begin
        @(negedge clk);

        // Free-running 1-cycle memory: latency and back-to-back delivery.
        lat_min = 1; lat_max = 1;
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        do_reset();
        cycle();
        chk("first_req_valid", {63'h0, s_rv}, 64'h1);
        chk("first_req_addr", s_ra, 64'h2000);
        cycle();
        chk("iv_t1", {63'h0, s_iv}, 64'h0);
        cycle();
        chk("iv_t2", {63'h0, s_iv}, 64'h1);
        chk("pc_t2", s_ipc, 64'h2000);
        cycle();
        chk("pc_t3", s_ipc, 64'h2004);
        cycle();
        chk("pc_t4", s_ipc, 64'h2008);

        // Stalled consumer: credit limit of 4, one pop frees exactly one request.
        inst_ready = 1'b0;
        do_reset();
        f0 = n_fire;
        repeat (10) cycle();
        chk("credit_fires", 64'(n_fire - f0), 64'd4);
        chk("credit_last", last_fire, 64'h200C);
        chk("credit_idle", {63'h0, s_rv}, 64'h0);
        inst_ready = 1'b1;
        cycle();
        inst_ready = 1'b0;
        f0 = n_fire;
        repeat (6) cycle();
        chk("refill_fires", 64'(n_fire - f0), 64'd1);
        chk("refill_addr", last_fire, 64'h2010);

        // Redirect with 3 slow responses in flight: all are dropped.
        lat_min = 5; lat_max = 5;
        inst_ready = 1'b1;
        do_reset();
        repeat (3) cycle();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 64'h3002;
        cycle();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        f0 = n_fire; p0 = n_pop;
        for (int i = 0; i < 10 && n_fire == f0; i++) cycle();
        chk("redir_req_addr", last_fire, 64'h3000);
        for (int i = 0; i < 30 && n_pop == p0; i++) cycle();
        chk("redir_first_pc", last_pop_pc, 64'h3000);

        // Redirect coinciding with a response and a pop.
        lat_min = 1; lat_max = 1;
        do_reset();
        repeat (5) cycle();
        #1;
        chk("coinc_rsp_pre", {63'h0, imem_rsp_valid}, 64'h1);
        chk("coinc_iv_pre", {63'h0, inst_valid}, 64'h1);
        redirect_valid = 1'b1;
        redirect_pc = 64'h5000;
        cycle();
        redirect_valid = 1'b0;
        #1;
        chk("coinc_flushed", {63'h0, inst_valid}, 64'h0);
        p0 = n_pop;
        for (int i = 0; i < 10 && n_pop == p0; i++) cycle();
        chk("coinc_next_pc", last_pop_pc, 64'h5000);

        // Halt with 2 outstanding: drain, stay halted, resume only on redirect.
        lat_min = 4; lat_max = 4;
        do_reset();
        repeat (2) cycle();
        halt = 1'b1;
        f0 = n_fire; p0 = n_pop;
        repeat (10) cycle();
        chk("halt_fires", 64'(n_fire - f0), 64'd0);
        chk("halt_pops", 64'(n_pop - p0), 64'd2);
        halt = 1'b0;
        repeat (5) cycle();
        chk("unhalt_fires", 64'(n_fire - f0), 64'd0);
        chk("unhalt_idle", {63'h0, s_rv}, 64'h0);
        redirect_valid = 1'b1;
        redirect_pc = 64'h4000;
        cycle();
        redirect_valid = 1'b0;
        f0 = n_fire;
        for (int i = 0; i < 5 && n_fire == f0; i++) cycle();
        chk("resume_addr", last_fire, 64'h4000);
        repeat (10) cycle();

        // PC wrap at the top of the address space.
        lat_min = 1; lat_max = 1;
        do_reset();
        repeat (4) cycle();
        redirect_valid = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        cycle();
        redirect_valid = 1'b0;
        f0 = n_fire;
        for (int i = 0; i < 5 && n_fire == f0; i++) cycle();
        chk("wrap_addr0", last_fire, 64'hFFFF_FFFF_FFFF_FFFC);
        for (int i = 0; i < 5 && n_fire == f0 + 1; i++) cycle();
        chk("wrap_addr1", last_fire, 64'h0);
        repeat (6) cycle();

        // Randomized traffic against the reference model, with one mid-run reset.
        lat_min = 1; lat_max = 4;
        do_reset();
        p0 = n_pop;
        for (int i = 0; i < 1500; i++) begin
            imem_req_ready = ($urandom_range(3, 0) != 0);
            inst_ready     = ($urandom_range(3, 0) != 0);
            if ($urandom_range(49, 0) == 0) halt = ~halt;
            redirect_valid = ($urandom_range(29, 0) == 0);
            redirect_pc    = {$urandom, $urandom};
            if (i == 700) begin
                do_reset();
            end else begin
                cycle();
            end
        end
        redirect_valid = 1'b0;
        halt = 1'b0;
        inst_ready = 1'b1;
        imem_req_ready = 1'b1;
        repeat (10) cycle();
        chk("random_progress", {63'h0, (n_pop - p0) > 100}, 64'h1);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
